// File: rtl/gray_counter_pkg.sv
// Shared constants for the Gray-coded up/down counter: mode encodings and
// the legal width range with a helper used by the elaboration check.
package gray_counter_pkg;

  localparam int GRAY_MODE_WRAP = 0;
  localparam int GRAY_MODE_SAT  = 1;

  localparam int GRAY_WIDTH_MIN = 2;
  localparam int GRAY_WIDTH_MAX = 16;

  function automatic bit gray_width_legal(input int w);
    return (w >= GRAY_WIDTH_MIN) && (w <= GRAY_WIDTH_MAX);
  endfunction

  function automatic bit gray_mode_legal(input int m);
    return (m == GRAY_MODE_WRAP) || (m == GRAY_MODE_SAT);
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and status bundle of the Gray counter; the counter is the slave,
// whoever steers it (user logic or a bench) is the master.
interface gray_counter_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             wrap;
  logic             at_limit;

  modport master (
    output en, up, load, load_val,
    input  bin, gray, wrap, at_limit
  );

  modport slave (
    input  en, up, load, load_val,
    output bin, gray, wrap, at_limit
  );

endinterface

// File: rtl/gray_counter_bin_to_gray_n.sv
// Purely combinational N-bit binary to reflected Gray converter.
module bin_to_gray_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Registered up/down counter exposing binary and Gray views of the same state,
// with synchronous load and selectable wrap or saturate behaviour at the limits.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = GRAY_MODE_WRAP
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_counter_if.slave  io_bus
);

  if (!gray_width_legal(WIDTH)) begin : g_bad_width
    $error("gray_counter: WIDTH=%0d outside %0d..%0d", WIDTH, GRAY_WIDTH_MIN, GRAY_WIDTH_MAX);
  end
  if (!gray_mode_legal(SATURATE)) begin : g_bad_mode
    $error("gray_counter: SATURATE=%0d is not a known mode", SATURATE);
  end

  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);
  localparam bit               LP_SAT = (SATURATE == GRAY_MODE_SAT);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic             w_at_max;
  logic             w_at_min;
  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;

  assign w_at_max = &r_bin;
  assign w_at_min = ~|r_bin;

  // Next-state mux: load beats count, count beats hold; limits wrap or stick.
  always_comb begin
    w_next_bin  = r_bin;
    w_next_wrap = 1'b0;
    if (io_bus.load) begin
      w_next_bin = io_bus.load_val;
    end else if (io_bus.en) begin
      if (io_bus.up) begin
        if (!w_at_max) begin
          w_next_bin = r_bin + LP_ONE;
        end else if (!LP_SAT) begin
          w_next_bin  = '0;
          w_next_wrap = 1'b1;
        end
      end else begin
        if (!w_at_min) begin
          w_next_bin = r_bin - LP_ONE;
        end else if (!LP_SAT) begin
          w_next_bin  = '1;
          w_next_wrap = 1'b1;
        end
      end
    end
  end

  // Gray is formed from the next binary value so both registers update together.
  bin_to_gray_n #(
    .WIDTH (WIDTH)
  ) u_bin_to_gray (
    .i_bin  (w_next_bin),
    .o_gray (w_next_gray)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_wrap <= w_next_wrap;
    end
  end

  assign io_bus.bin      = r_bin;
  assign io_bus.gray     = r_gray;
  assign io_bus.wrap     = r_wrap;
  assign io_bus.at_limit = io_bus.up ? w_at_max : w_at_min;

endmodule
